// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern sequencer: mode codes, direction
// encoding and the pattern shown after reset.
package led_pkg;

   localparam logic [1:0] MODE_LEFT   = 2'b00;
   localparam logic [1:0] MODE_RIGHT  = 2'b01;
   localparam logic [1:0] MODE_BOUNCE = 2'b10;
   localparam logic [1:0] MODE_HOLD   = 2'b11;

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } dir_t;

   // Bit 0 lit; widened to WIDTH at the point of use.
   localparam int LED_RESET_PATTERN = 1;

endpackage

// File: rtl/led_shift_seq_tick_gen.sv
// Prescaler: counts enabled cycles 0..TICK_DIV-1 and flags the wrap cycle as a tick.
// clr restarts the count so the next tick lands TICK_DIV enabled cycles later.
module tick_gen #(
   parameter int TICK_DIV = 50_000_000,
   parameter int DIV_W    = $clog2(TICK_DIV) + 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

   logic [DIV_W-1:0] count;

   // Prescaler counter: reset and clear restart it, disabled cycles freeze it.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         if (count == LAST) begin
            count <= '0;
         end else begin
            count <= count + DIV_W'(1);
         end
      end
   end

   assign tick = en & (count == LAST);

endmodule

// File: rtl/led_shift_seq.sv
// LED pattern sequencer: rotates a WIDTH-bit pattern left, right, ping-pong
// or holds it, one step per prescaler tick; load overrides any tick.
module led_shift_seq
   import led_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int TICK_DIV = 50_000_000,
   parameter int DIV_W    = $clog2(TICK_DIV) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_pattern,
   output logic [WIDTH-1:0] data_out,
   output logic             step_o,
   output logic             dir_o
);

   logic             tick;
   dir_t             dir;
   dir_t             dir_next;
   logic [WIDTH-1:0] data_next;
   logic             step_next;
   logic [WIDTH-1:0] rot_left;
   logic [WIDTH-1:0] rot_right;

   tick_gen #(
      .TICK_DIV (TICK_DIV),
      .DIV_W    (DIV_W)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .clr  (load),
      .tick (tick)
   );

   assign rot_left  = {data_out[WIDTH-2:0], data_out[WIDTH-1]};
   assign rot_right = {data_out[0], data_out[WIDTH-1:1]};

   // Pattern, direction and step pulse registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_out <= WIDTH'(LED_RESET_PATTERN);
         dir      <= DIR_LEFT;
         step_o   <= 1'b0;
      end else begin
         data_out <= data_next;
         dir      <= dir_next;
         step_o   <= step_next;
      end
   end

   // Next pattern/direction; a load discards a coincident tick.
   always_comb begin
      data_next = data_out;
      dir_next  = dir;
      step_next = 1'b0;
      if (load) begin
         data_next = load_pattern;
         dir_next  = DIR_LEFT;
      end else if (tick) begin
         case (mode)
            MODE_LEFT: begin
               data_next = rot_left;
               dir_next  = DIR_LEFT;
               step_next = 1'b1;
            end
            MODE_RIGHT: begin
               data_next = rot_right;
               dir_next  = DIR_RIGHT;
               step_next = 1'b1;
            end
            MODE_BOUNCE: begin
               step_next = 1'b1;
               // Turn around at an edge and move away from it in the same tick.
               case (dir)
                  DIR_LEFT: begin
                     if (data_out[WIDTH-1]) begin
                        dir_next  = DIR_RIGHT;
                        data_next = rot_right;
                     end else begin
                        dir_next  = DIR_LEFT;
                        data_next = rot_left;
                     end
                  end
                  DIR_RIGHT: begin
                     if (data_out[0]) begin
                        dir_next  = DIR_LEFT;
                        data_next = rot_left;
                     end else begin
                        dir_next  = DIR_RIGHT;
                        data_next = rot_right;
                     end
                  end
                  default: begin
                     dir_next  = DIR_LEFT;
                     data_next = data_out;
                  end
               endcase
            end
            MODE_HOLD: begin
               data_next = data_out;
               dir_next  = dir;
               step_next = 1'b0;
            end
            default: begin
               data_next = data_out;
               dir_next  = dir;
               step_next = 1'b0;
            end
         endcase
      end else begin
         data_next = data_out;
         dir_next  = dir;
         step_next = 1'b0;
      end
   end

   assign dir_o = dir;

endmodule

// File: tb/tb_led_shift_seq.sv
// Directed bench for led_shift_seq at WIDTH=4, TICK_DIV=4: a per-cycle vector
// table for the three rotating modes plus hand-written multi-cycle sequences.
module tb_led_shift_seq;

   localparam int WIDTH    = 4;
   localparam int TICK_DIV = 4;

   typedef struct {
      logic       rst;
      logic       en;
      logic [1:0] mode;
      logic       load;
      logic [3:0] load_pattern;
      logic [3:0] exp_data;
      logic       exp_step;
      logic       exp_dir;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [1:0] mode;
   logic       load;
   logic [3:0] load_pattern;
   logic [3:0] data_out;
   logic       step_o;
   logic       dir_o;

   int checks = 0;
   int errors = 0;
   vec_t vecs[$];

   led_shift_seq #(
      .WIDTH    (WIDTH),
      .TICK_DIV (TICK_DIV)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .mode         (mode),
      .load         (load),
      .load_pattern (load_pattern),
      .data_out     (data_out),
      .step_o       (step_o),
      .dir_o        (dir_o)
   );

   always #5 clk = ~clk;

   task automatic cycle(input logic r, input logic e, input logic [1:0] m,
                        input logic l, input logic [3:0] lp);
      rst = r; en = e; mode = m; load = l; load_pattern = lp;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string name, input logic [3:0] d,
                             input logic s, input logic dr);
      checks++;
      if (data_out !== d || step_o !== s || dir_o !== dr) begin
         errors++;
         $display("FAIL %s: got data=%h step=%b dir=%b, expected data=%h step=%b dir=%b",
                  name, data_out, step_o, dir_o, d, s, dr);
      end
   endtask

   // One reset row, then nticks groups of 4 rows: 3 idle cycles and a tick.
   task automatic add_scenario(input logic [1:0] m, input logic [3:0] seq[9],
                               input logic dseq[9], input int nticks);
      vecs.push_back('{1'b1, 1'b0, m, 1'b0, 4'h0, 4'h1, 1'b0, 1'b0});
      for (int t = 0; t < nticks; t++) begin
         for (int k = 0; k < 3; k++)
            vecs.push_back('{1'b0, 1'b1, m, 1'b0, 4'h0, seq[t], 1'b0, dseq[t]});
         vecs.push_back('{1'b0, 1'b1, m, 1'b0, 4'h0, seq[t+1], 1'b1, dseq[t+1]});
      end
   endtask

   initial begin
      logic [3:0] left_seq[9]   = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
      logic       left_dir[9]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [3:0] right_seq[9]  = '{4'h1, 4'h8, 4'h4, 4'h2, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
      logic       right_dir[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [3:0] bounce_seq[9] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2, 4'h4};
      logic       bounce_dir[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

      add_scenario(2'b00, left_seq, left_dir, 4);
      add_scenario(2'b01, right_seq, right_dir, 4);
      add_scenario(2'b10, bounce_seq, bounce_dir, 8);

      rst = 1'b1; en = 1'b0; mode = 2'b00; load = 1'b0; load_pattern = 4'h0;
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < vecs.size(); i++) begin
         cycle(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].load, vecs[i].load_pattern);
         expect_out($sformatf("table[%0d]", i), vecs[i].exp_data, vecs[i].exp_step,
                    vecs[i].exp_dir);
      end

      // en low for 5 cycles mid-count delays the first update by exactly 5.
      cycle(1'b1, 1'b0, 2'b00, 1'b0, 4'h0);
      expect_out("stall_reset", 4'h1, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
         cycle(1'b0, 1'b1, 2'b00, 1'b0, 4'h0);
         expect_out("stall_pre", 4'h1, 1'b0, 1'b0);
      end
      for (int k = 0; k < 5; k++) begin
         cycle(1'b0, 1'b0, 2'b00, 1'b0, 4'h0);
         expect_out("stall_frozen", 4'h1, 1'b0, 1'b0);
      end
      cycle(1'b0, 1'b1, 2'b00, 1'b0, 4'h0);
      expect_out("stall_post", 4'h1, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 2'b00, 1'b0, 4'h0);
      expect_out("stall_tick", 4'h2, 1'b1, 1'b0);

      // Load coincident with a tick wins; next tick 4 cycles later.
      cycle(1'b1, 1'b0, 2'b00, 1'b0, 4'h0);
      for (int k = 0; k < 3; k++)
         cycle(1'b0, 1'b1, 2'b00, 1'b0, 4'h0);
      expect_out("load_pre", 4'h1, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 2'b00, 1'b1, 4'b1001);
      expect_out("load_vs_tick", 4'h9, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         cycle(1'b0, 1'b1, 2'b00, 1'b0, 4'h0);
         expect_out("load_wait", 4'h9, 1'b0, 1'b0);
      end
      cycle(1'b0, 1'b1, 2'b00, 1'b0, 4'h0);
      expect_out("load_next_tick", 4'h3, 1'b1, 1'b0);

      // Load while disabled, from RIGHT direction, returns dir to LEFT.
      cycle(1'b0, 1'b1, 2'b01, 1'b0, 4'h0);
      cycle(1'b0, 1'b1, 2'b01, 1'b0, 4'h0);
      cycle(1'b0, 1'b1, 2'b01, 1'b0, 4'h0);
      cycle(1'b0, 1'b1, 2'b01, 1'b0, 4'h0);
      expect_out("right_from_3", 4'h9, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 2'b01, 1'b1, 4'b0101);
      expect_out("load_en_low", 4'h5, 1'b0, 1'b0);

      // Reset in the middle of bounce, on a cycle that would have ticked.
      cycle(1'b1, 1'b0, 2'b10, 1'b0, 4'h0);
      for (int k = 0; k < 16; k++)
         cycle(1'b0, 1'b1, 2'b10, 1'b0, 4'h0);
      expect_out("bounce_mid", 4'h4, 1'b1, 1'b1);
      for (int k = 0; k < 3; k++)
         cycle(1'b0, 1'b1, 2'b10, 1'b0, 4'h0);
      cycle(1'b1, 1'b1, 2'b10, 1'b0, 4'h0);
      expect_out("bounce_rst", 4'h1, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         cycle(1'b0, 1'b1, 2'b10, 1'b0, 4'h0);
         expect_out("bounce_restart_wait", 4'h1, 1'b0, 1'b0);
      end
      cycle(1'b0, 1'b1, 2'b10, 1'b0, 4'h0);
      expect_out("bounce_restart", 4'h2, 1'b1, 1'b0);

      // HOLD: no change, no step, but the prescaler keeps running.
      cycle(1'b1, 1'b0, 2'b11, 1'b0, 4'h0);
      for (int k = 0; k < 4; k++) begin
         cycle(1'b0, 1'b1, 2'b11, 1'b0, 4'h0);
         expect_out("hold", 4'h1, 1'b0, 1'b0);
      end
      for (int k = 0; k < 3; k++)
         cycle(1'b0, 1'b1, 2'b00, 1'b0, 4'h0);
      expect_out("hold_exit_wait", 4'h1, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 2'b00, 1'b0, 4'h0);
      expect_out("hold_exit_tick", 4'h2, 1'b1, 1'b0);

      // All-zero pattern still produces step pulses.
      cycle(1'b0, 1'b1, 2'b00, 1'b1, 4'h0);
      expect_out("zero_load", 4'h0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++)
         cycle(1'b0, 1'b1, 2'b00, 1'b0, 4'h0);
      cycle(1'b0, 1'b1, 2'b00, 1'b0, 4'h0);
      expect_out("zero_tick", 4'h0, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
